if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS core; sits directly upstream of the instruction ROM.
- Owns the PC register and drives the ROM chip-enable and byte address.
- Captures the ROM's combinational instruction word into the IF/ID pipeline register.
- Handles pipeline stall, branch redirect with MIPS delay-slot semantics, exception flush, misaligned-fetch detection and a fetched-instruction counter.

Parameters:
- ADDR_W, 32, PC and ROM address width; equals the INST_ADDR_WIDTH define.
- DATA_W, 32, instruction width; equals the INST_DATA_WIDTH define.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- stall_if  in  1  from stall controller; freeze the PC.
- stall_id  in  1  from stall controller; freeze the IF/ID register.
- flush  in  1  exception/eret redirect; highest priority.
- flush_pc  in  ADDR_W  target PC when flush=1.
- branch_flag  in  1  taken branch/jump resolved in ID.
- branch_target  in  ADDR_W  target PC when branch_flag=1.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  ADDR_W  ROM byte address; always equals pc.
- rom_inst  in  DATA_W  combinational ROM data, valid in the same cycle as rom_addr.
- id_pc  out  ADDR_W  PC of the instruction held in IF/ID.
- id_inst  out  DATA_W  instruction held in IF/ID; 0 (NOP) when it is a bubble.
- id_valid  out  1  IF/ID holds a real instruction.
- id_adel  out  1  instruction-fetch address error: PC[1:0] is not 0.
- fetch_cnt  out  32  count of valid instructions accepted into ID; wraps.

Behaviour:
- Reset (async assert) sets: pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_valid=0, id_adel=0, fetch_cnt=0.
- Reset deassertion:
  - First rising edge after deassert sets rom_ce=1; pc stays RESET_PC.
  - rom_ce then stays 1 until the next reset.
  - While rom_ce=0, the PC does not advance and IF/ID loads a bubble.
- PC next-state priority, evaluated only when rom_ce=1:
  - flush → flush_pc
  - else stall_if → hold
  - else branch_flag → branch_target
  - else pc+4
  - pc+4 wraps modulo 2^ADDR_W.
- Branch/stall interaction:
  - branch_flag arriving while stall_if=1 is ignored.
  - ID re-presents branch_flag on every cycle it is stalled, so no request is lost.
- Delay slot:
  - A branch does not flush IF/ID; the instruction fetched in the cycle branch_flag is asserted enters ID normally.
  - Sequence in ID: branch, delay slot, target.
- IF/ID update, evaluated each edge:
  - flush → bubble (id_inst=0, id_valid=0, id_adel=0, id_pc=0).
  - else stall_id=1 → hold all IF/ID outputs.
  - else stall_if=1 → bubble.
  - else rom_ce=0 → bubble.
  - else load id_pc=pc and id_valid=1.
    - If pc[1:0]≠0: id_adel=1 and id_inst=0; the ROM word is discarded.
    - Otherwise: id_adel=0 and id_inst=rom_inst.
- Misaligned PC:
  - A misaligned PC keeps incrementing by 4 until a flush arrives.
  - The exception unit is responsible for that flush.
- fetch_cnt increments on every edge where IF/ID loads with id_valid=1, including id_adel entries.
- Latency:
  - PC-to-ID is 1 cycle.
  - Branch-to-target-in-ID is 2 cycles, with the delay slot in between.
  - Flush-to-target-in-ID is 1 cycle of bubble plus 1 cycle.
- Async reset mid-stall or mid-flush restores all reset values immediately; no pending redirect survives.

Decomposition:
- Shared defines, in the existing defines file:
  - INST_ADDR_WIDTH
  - INST_DATA_WIDTH
  - RESET_PC constant
  - NOP_INST = 32'h0
  - PC_STEP = 4
- Natural sub-module `if_id_reg`: the IF/ID pipeline register with its bubble/hold/load priority and fetch_cnt.
- if_stage instantiates if_id_reg and keeps the PC/ce logic itself.

Test Plan:
- Reset release with ROM[0..3]=A,B,C,D and no stalls:
  - rom_ce rises 1 cycle after rst_n.
  - rom_addr runs 0,4,8,C.
  - id_inst shows A,B,C,D one cycle later with id_valid=1.
  - fetch_cnt=4 after four loads.
- Branch: branch_flag=1 for one cycle while pc=0x8, branch_target=0x40 → next pc=0x40; ID sequence is inst@0x4 (branch), inst@0x8 (delay slot), inst@0x40.
- Stall:
  - stall_if=1 with stall_id=0 for 2 cycles at pc=0x10 → pc holds 0x10; ID receives 2 bubbles (id_valid=0, id_inst=0); fetch_cnt unchanged.
  - stall_if=stall_id=1 → IF/ID holds its previous value.
- Flush beats branch and stall: flush=1, flush_pc=0x180, branch_flag=1, stall_if=1 in the same cycle → pc=0x180; ID shows a bubble, then inst@0x180 on the next edge.
- Misaligned: branch_target=0x42 → next ID entry has id_pc=0x42, id_adel=1, id_inst=0, id_valid=1; then flush to 0x180 recovers.
- Async reset mid-stream: assert rst_n=0 between edges at pc=0x24 → all outputs return to reset values without a clock edge; restart fetches from RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage of the MIPS core.
package if_stage_pkg;

  // Instruction address and data widths used across the core.
  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_DATA_WIDTH = 32;

  // Reset vector, bubble encoding and sequential PC increment.
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // ROM chip-enable sequencer: off in reset, on from the first edge after release.
  typedef enum logic {
    CE_OFF = 1'b0,
    CE_ON  = 1'b1
  } ce_state_e;

  // Source selected for the next PC.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_FLUSH  = 2'd1,
    PC_BRANCH = 2'd2,
    PC_SEQ    = 2'd3
  } pc_sel_e;

  // Operation applied to the IF/ID register on an edge.
  typedef enum logic [1:0] {
    IFID_BUBBLE = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

  // A fetch address is word-aligned only when its two low bits are zero.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble/hold/load selection, fetch-error tagging
// and the count of valid instructions handed to decode.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int DATA_W = INST_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall_id,
  input  logic              stall_if,
  input  logic              rom_ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel,
  output logic [31:0]       fetch_cnt
);

  ifid_op_e op;
  logic     fetch_err;

  assign fetch_err = is_misaligned(pc[1:0]);

  // Decide what the register does this edge; flush beats a decode stall,
  // which beats a fetch stall or a disabled ROM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    op = IFID_LOAD;
    if (flush) begin
      op = IFID_BUBBLE;
    end else if (stall_id) begin
      op = IFID_HOLD;
    end else if (stall_if || !rom_ce) begin
      op = IFID_BUBBLE;
    end
  end

  // Pipeline register and fetched-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc     <= '0;
      id_inst   <= DATA_W'(NOP_INST);
      id_valid  <= 1'b0;
      id_adel   <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (op)
        IFID_BUBBLE: begin
          id_pc    <= '0;
          id_inst  <= DATA_W'(NOP_INST);
          id_valid <= 1'b0;
          id_adel  <= 1'b0;
        end
        IFID_LOAD: begin
          id_pc     <= pc;
          // A misaligned fetch discards the ROM word and carries the error instead.
          id_inst   <= fetch_err ? DATA_W'(NOP_INST) : rom_inst;
          id_valid  <= 1'b1;
          id_adel   <= fetch_err;
          fetch_cnt <= fetch_cnt + 32'd1;
        end
        default: begin
          id_pc    <= id_pc;
          id_inst  <= id_inst;
          id_valid <= id_valid;
          id_adel  <= id_adel;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM enable/address, and the IF/ID
// register fed from the combinational ROM output.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_WIDTH,
  parameter int                DATA_W   = INST_DATA_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel,
  output logic [31:0]       fetch_cnt
);

  ce_state_e         ce_state_q;
  ce_state_e         ce_state_d;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Chip-enable sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ce_state_q <= CE_OFF;
    end else begin
      ce_state_q <= ce_state_d;
    end
  end

  // Enable the ROM on the first edge after reset and keep it on.
  always_comb begin
    ce_state_d = ce_state_q;
    case (ce_state_q)
      CE_OFF:  ce_state_d = CE_ON;
      CE_ON:   ce_state_d = CE_ON;
      default: ce_state_d = CE_OFF;
    endcase
  end

  assign rom_ce = (ce_state_q == CE_ON);

  // Next-PC source: flush, then fetch stall, then a taken branch, then pc+4.
  // A branch seen while fetch is stalled is dropped; decode re-presents it.
  always_comb begin
    pc_sel = PC_HOLD;
    if (rom_ce) begin
      if (flush) begin
        pc_sel = PC_FLUSH;
      end else if (stall_if) begin
        pc_sel = PC_HOLD;
      end else if (branch_flag) begin
        pc_sel = PC_BRANCH;
      end else begin
        pc_sel = PC_SEQ;
      end
    end
  end

  // Next-PC value for the selected source; pc+4 wraps naturally.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_FLUSH:  pc_d = flush_pc;
      PC_BRANCH: pc_d = branch_target;
      PC_SEQ:    pc_d = pc_q + ADDR_W'(PC_STEP);
      default:   pc_d = pc_q;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign rom_addr = pc_q;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stall_id  (stall_id),
    .stall_if  (stall_if),
    .rom_ce    (rom_ce),
    .pc        (pc_q),
    .rom_inst  (rom_inst),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .id_adel   (id_adel),
    .fetch_cnt (fetch_cnt)
  );

endmodule
